// File: rtl/ex_if.sv
// Execute-stage port bundle: ID/EX operands and control in, EX/MEM register contents out.
interface ex_if #(parameter int WIDTH = 32);
  logic             flush;
  logic [WIDTH-1:0] reg_a, reg_b, imm, add_pc_in;
  logic             select_alu_src;
  logic [3:0]       alu_op;
  logic             mem_we_in, mem_re_in, branch_in, reg_file_write_in;
  logic [1:0]       select_mux_4_in, select_mux_2_in;

  logic             stall_out, zero_out;
  logic [WIDTH-1:0] alu_out, reg_out_b, add_pc_out;
  logic             mem_we, mem_re, branch_out, reg_file_write_out;
  logic [1:0]       select_mux_4_out, select_mux_2_out;

  modport master (
    output flush, reg_a, reg_b, imm, add_pc_in, select_alu_src, alu_op,
           mem_we_in, mem_re_in, branch_in, reg_file_write_in,
           select_mux_4_in, select_mux_2_in,
    input  stall_out, zero_out, alu_out, reg_out_b, add_pc_out,
           mem_we, mem_re, branch_out, reg_file_write_out,
           select_mux_4_out, select_mux_2_out
  );

  modport slave (
    input  flush, reg_a, reg_b, imm, add_pc_in, select_alu_src, alu_op,
           mem_we_in, mem_re_in, branch_in, reg_file_write_in,
           select_mux_4_in, select_mux_2_in,
    output stall_out, zero_out, alu_out, reg_out_b, add_pc_out,
           mem_we, mem_re, branch_out, reg_file_write_out,
           select_mux_4_out, select_mux_2_out
  );
endinterface

// File: rtl/ex.sv
// Execute stage: single-cycle ALU plus iterative shift-add multiplier / restoring
// divider, feeding an internal EX/MEM register.
module ex #(
   parameter int WIDTH = 32
) (
   input logic clk,
   input logic reset,
   ex_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] opnd_q, hi, lo;

   logic [WIDTH-1:0] a, b, alu_res, mc_res, res;
   logic             is_multi, stall, start, step, load_res, load_bub;

   // Iteration datapath
   logic [WIDTH:0]   mul_sum, div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem;

   assign a = bus.reg_a;
   assign b = bus.select_alu_src ? bus.imm : bus.reg_b;
   assign is_multi = (bus.alu_op >= 4'd10) && (bus.alu_op <= 4'd13);

   always_comb begin
      alu_res = b;
      case (bus.alu_op)
         4'd0: alu_res = a + b;
         4'd1: alu_res = a - b;
         4'd2: alu_res = a & b;
         4'd3: alu_res = a | b;
         4'd4: alu_res = a ^ b;
         4'd5: alu_res = a << b[4:0];
         4'd6: alu_res = a >> b[4:0];
         4'd7: alu_res = $signed(a) >>> b[4:0];
         4'd8: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         4'd9: alu_res = {{(WIDTH-1){1'b0}}, a < b};
         default: alu_res = b;
      endcase
   end

   // {hi,lo} shifts right as the multiplicand is accumulated into hi;
   // for divide, hi is the partial remainder and lo collects quotient bits.
   always_comb begin
      mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opnd_q : {WIDTH{1'b0}})};
      div_shift = {hi, lo[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opnd_q};
      div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
   end

   always_comb begin
      case (op_q)
         4'd10, 4'd12: mc_res = lo;
         default:      mc_res = hi;
      endcase
   end

   assign res = (state == DONE) ? mc_res : alu_res;

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      start     = 1'b0;
      step      = 1'b0;
      load_res  = 1'b0;
      load_bub  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.flush) begin
               load_bub = 1'b1;
            end else if (is_multi) begin
               stall     = 1'b1;
               start     = 1'b1;
               load_bub  = 1'b1;
               state_nxt = BUSY;
            end else begin
               load_res = 1'b1;
            end
         end
         BUSY: begin
            stall    = 1'b1;
            load_bub = 1'b1;
            if (bus.flush) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == CW'(WIDTH-1)) state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            if (bus.flush) load_bub = 1'b1;
            else           load_res = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.stall_out = stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         opnd_q <= '0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            op_q   <= bus.alu_op;
            opnd_q <= b;
            hi     <= '0;
            lo     <= a;
            cnt    <= '0;
         end else if (step) begin
            cnt <= cnt + 1'b1;
            if (op_q[3:2] == 2'b10) begin
               hi <= mul_sum[WIDTH:1];
               lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end else begin
               hi <= div_rem;
               lo <= {lo[WIDTH-2:0], div_ge};
            end
         end
      end
   end

   // EX/MEM register: bubbles clear control and zero_out but hold the data fields.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.alu_out            <= '0;
         bus.zero_out           <= 1'b0;
         bus.reg_out_b          <= '0;
         bus.add_pc_out         <= '0;
         bus.mem_we             <= 1'b0;
         bus.mem_re             <= 1'b0;
         bus.branch_out         <= 1'b0;
         bus.reg_file_write_out <= 1'b0;
         bus.select_mux_4_out   <= '0;
         bus.select_mux_2_out   <= '0;
      end else if (load_res) begin
         bus.alu_out            <= res;
         bus.zero_out           <= (res == '0);
         bus.reg_out_b          <= bus.reg_b;
         bus.add_pc_out         <= bus.add_pc_in;
         bus.mem_we             <= bus.mem_we_in;
         bus.mem_re             <= bus.mem_re_in;
         bus.branch_out         <= bus.branch_in;
         bus.reg_file_write_out <= bus.reg_file_write_in;
         bus.select_mux_4_out   <= bus.select_mux_4_in;
         bus.select_mux_2_out   <= bus.select_mux_2_in;
      end else if (load_bub) begin
         bus.zero_out           <= 1'b0;
         bus.mem_we             <= 1'b0;
         bus.mem_re             <= 1'b0;
         bus.branch_out         <= 1'b0;
         bus.reg_file_write_out <= 1'b0;
      end
   end
endmodule
